// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load bubbles, branch flush, ECALL halt and multi-cycle MDU busy.
// Optional macro PIPE_HAZARD_DIV_LAT_EN gives divides their own DIV_LAT latency.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_NOP_CYC = 1,
    parameter int unsigned FLUSH_CYC    = 1,
    parameter int unsigned MUL_LAT      = 6,
    parameter int unsigned DIV_LAT      = 16,
    parameter int unsigned CW           = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wake,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       nop,
    output logic       halt,
    output logic       flush,
    output logic       mdu_busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StWork  = 3'b000,
        StNop   = 3'b010,
        StHalt  = 3'b011,
        StFlush = 3'b100,
        StMdu   = 3'b101
    } state_e;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpEcall = 7'b1110011;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] F7Mdu   = 7'b0000001;

`ifdef PIPE_HAZARD_DIV_LAT_EN
    localparam bit DivLatEn = 1'b1;
`else
    localparam bit DivLatEn = 1'b0;
`endif

    // Counter holds (length - 1); a length of 2^CW therefore loads all-ones.
    localparam logic [CW-1:0] NopLen   = CW'(LOAD_NOP_CYC - 1);
    localparam logic [CW-1:0] FlushLen = CW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] MulLen   = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DivLen   = CW'(DIV_LAT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_mdu;
    logic          is_div;
    logic [CW-1:0] mdu_len;
    logic          cnt_zero;
    logic          unused_funct3;

    assign is_mdu        = (opcode == OpReg) && (funct7 == F7Mdu);
    assign is_div        = funct3[2];
    assign mdu_len       = (is_div && DivLatEn) ? DivLen : MulLen;
    assign cnt_zero      = (cnt_q == '0);
    assign unused_funct3 = ^funct3[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWork;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StWork: begin
                if (!stall) begin
                    if (branch_taken) begin
                        state_d = StFlush;
                        cnt_d   = FlushLen;
                    end else if (opcode == OpLoad) begin
                        state_d = StNop;
                        cnt_d   = NopLen;
                    end else if (opcode == OpEcall) begin
                        state_d = StHalt;
                    end else if (is_mdu) begin
                        state_d = StMdu;
                        cnt_d   = mdu_len;
                    end
                end
            end
            StNop, StMdu: begin
                if (!stall) begin
                    if (cnt_zero) state_d = StWork;
                    else          cnt_d   = cnt_q - CW'(1);
                end
            end
            // Flush must always drain, so stall is deliberately not consulted.
            StFlush: begin
                if (cnt_zero) state_d = StWork;
                else          cnt_d   = cnt_q - CW'(1);
            end
            StHalt: begin
                if (!stall && wake) state_d = StWork;
            end
            default: begin
                state_d = StWork;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        nop      = (state_q == StNop);
        halt     = (state_q == StHalt);
        flush    = (state_q == StFlush);
        mdu_busy = (state_q == StMdu);
        state    = state_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner sequences and
// randomized traffic against a cycles-remaining reference model.
module tb_pipe_hazard_ctrl;

    localparam int LOAD_N = 1;
    localparam int FLUSH_N = 2;
    localparam int MUL_N = 6;
    localparam int DIV_N = 16;
`ifdef PIPE_HAZARD_DIV_LAT_EN
    localparam int DIV_EXP = DIV_N;
`else
    localparam int DIV_EXP = MUL_N;
`endif

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ECALL = 7'b1110011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    logic       clk = 1'b0;
    logic       rst, wake, stall, branch_taken;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       nop, halt, flush, mdu_busy;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(
        .LOAD_NOP_CYC(LOAD_N),
        .FLUSH_CYC   (FLUSH_N),
        .MUL_LAT     (MUL_N),
        .DIV_LAT     (DIV_N),
        .CW          (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wake        (wake),
        .stall       (stall),
        .branch_taken(branch_taken),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .nop         (nop),
        .halt        (halt),
        .flush       (flush),
        .mdu_busy    (mdu_busy),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Reference model: which hazard is showing and how many visible cycles it still owes.
    localparam int K_WORK = 0, K_NOP = 1, K_HALT = 2, K_FLUSH = 3, K_MDU = 4;
    int m_kind = K_WORK;
    int m_rem  = 0;

    function automatic logic [6:0] exp_of_kind(input int k);
        case (k)
            K_NOP:   return 7'b010_1000;
            K_HALT:  return 7'b011_0100;
            K_FLUSH: return 7'b100_0010;
            K_MDU:   return 7'b101_0001;
            default: return 7'b000_0000;
        endcase
    endfunction

    function automatic logic [6:0] obs();
        return {state, nop, halt, flush, mdu_busy};
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {state,nop,halt,flush,mdu}=%b expected %b at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_step();
        bit mdu_cls;
        mdu_cls = (opcode == OP_REG) && (funct7 == 7'b0000001);
        if (rst) begin
            m_kind = K_WORK;
            m_rem  = 0;
        end else begin
            case (m_kind)
                K_WORK: if (!stall) begin
                    if (branch_taken) begin m_kind = K_FLUSH; m_rem = FLUSH_N; end
                    else if (opcode == OP_LOAD) begin m_kind = K_NOP; m_rem = LOAD_N; end
                    else if (opcode == OP_ECALL) m_kind = K_HALT;
                    else if (mdu_cls) begin
                        m_kind = K_MDU;
                        m_rem  = funct3[2] ? DIV_EXP : MUL_N;
                    end
                end
                K_NOP, K_MDU: if (!stall) begin
                    m_rem--;
                    if (m_rem == 0) m_kind = K_WORK;
                end
                K_FLUSH: begin
                    m_rem--;
                    if (m_rem == 0) m_kind = K_WORK;
                end
                K_HALT: if (wake && !stall) m_kind = K_WORK;
                default: m_kind = K_WORK;
            endcase
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("model", obs(), exp_of_kind(m_kind));
    endtask

    task automatic idle();
        rst = 0; wake = 0; stall = 0; branch_taken = 0;
        opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0000000;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic br);
        opcode = op; funct3 = f3; funct7 = f7; branch_taken = br;
        cyc();
        idle();
    endtask

    task automatic count_run(input int which, output int n);
        logic s;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            s = (which == 0) ? nop : (which == 1) ? flush : mdu_busy;
            if (!s) break;
            n++;
            cyc();
        end
    endtask

    typedef struct {
        logic       rst, stall, wake, br;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] exp_state;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [6:0] decode(input logic [2:0] s);
        case (s)
            3'b010:  return 7'b010_1000;
            3'b011:  return 7'b011_0100;
            3'b100:  return 7'b100_0010;
            3'b101:  return 7'b101_0001;
            default: return 7'b000_0000;
        endcase
    endfunction

    initial begin
        int n;
        bit saw_nop;
        idle();
        vecs[0]  = '{1, 0, 0, 0, 7'h00,   3'b000, 7'h00, 3'b000};
        vecs[1]  = '{0, 0, 0, 0, OP_LOAD, 3'b000, 7'h00, 3'b010};
        vecs[2]  = '{0, 0, 0, 0, 7'h00,   3'b000, 7'h00, 3'b000};
        vecs[3]  = '{0, 0, 0, 1, OP_LOAD, 3'b000, 7'h00, 3'b100};
        vecs[4]  = '{0, 1, 0, 0, OP_LOAD, 3'b000, 7'h00, 3'b100};
        vecs[5]  = '{0, 1, 0, 0, 7'h00,   3'b000, 7'h00, 3'b000};
        vecs[6]  = '{0, 1, 0, 0, OP_LOAD, 3'b000, 7'h00, 3'b000};
        vecs[7]  = '{0, 0, 0, 0, OP_ECALL,3'b000, 7'h00, 3'b011};
        vecs[8]  = '{0, 1, 1, 0, 7'h00,   3'b000, 7'h00, 3'b011};
        vecs[9]  = '{0, 0, 0, 1, 7'h00,   3'b000, 7'h00, 3'b011};
        vecs[10] = '{0, 0, 1, 0, 7'h00,   3'b000, 7'h00, 3'b000};
        vecs[11] = '{0, 0, 1, 0, 7'h00,   3'b000, 7'h00, 3'b000};
        vecs[12] = '{0, 0, 0, 0, OP_REG,  3'b000, 7'h01, 3'b101};
        vecs[13] = '{0, 0, 0, 1, 7'h00,   3'b000, 7'h00, 3'b101};
        vecs[14] = '{1, 1, 0, 0, 7'h00,   3'b000, 7'h00, 3'b000};
        vecs[15] = '{0, 0, 0, 0, OP_REG,  3'b000, 7'h00, 3'b000};
        vecs[16] = '{0, 0, 0, 0, OP_REG,  3'b010, 7'h01, 3'b101};
        vecs[17] = '{1, 0, 0, 0, 7'h00,   3'b000, 7'h00, 3'b000};

        for (int i = 0; i < 18; i++) begin
            rst = vecs[i].rst; stall = vecs[i].stall; wake = vecs[i].wake;
            branch_taken = vecs[i].br; opcode = vecs[i].op;
            funct3 = vecs[i].f3; funct7 = vecs[i].f7;
            cyc();
            check($sformatf("vec%0d", i), obs(), decode(vecs[i].exp_state));
        end
        idle();
        cyc();

        // LOAD bubble length
        issue(OP_LOAD, 3'b000, 7'h00, 0);
        count_run(0, n);
        check_int("load_nop_len", n, LOAD_N);
        check("load_back_work", obs(), 7'b000_0000);

        // MUL, then MUL with a 2-cycle stall inside
        issue(OP_REG, 3'b000, 7'h01, 0);
        count_run(2, n);
        check_int("mul_len", n, MUL_N);
        issue(OP_REG, 3'b000, 7'h01, 0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!mdu_busy) break;
            n++;
            stall = (n == 3 || n == 4);
            cyc();
        end
        stall = 0;
        check_int("mul_stall_len", n, MUL_N + 2);

        // DIV latency depends on the build option
        issue(OP_REG, 3'b100, 7'h01, 0);
        count_run(2, n);
        check_int("div_len", n, DIV_EXP);

        // Branch beats LOAD; stall cannot stretch the flush
        issue(OP_LOAD, 3'b000, 7'h00, 1);
        saw_nop = 0;
        n = 0;
        stall = 1;
        for (int i = 0; i < 200; i++) begin
            if (nop) saw_nop = 1;
            if (!flush) break;
            n++;
            cyc();
        end
        if (nop) saw_nop = 1;
        stall = 0;
        check_int("flush_len", n, FLUSH_N);
        check_int("flush_no_nop", int'(saw_nop), 0);

        // ECALL halt, wake under stall ignored, wake alone releases
        issue(OP_ECALL, 3'b000, 7'h00, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (halt) n++;
            cyc();
        end
        check_int("halt_held", n, 10);
        wake = 1; stall = 1;
        cyc();
        check("halt_wake_stalled", obs(), 7'b011_0100);
        stall = 0;
        cyc();
        check("halt_wake", obs(), 7'b000_0000);
        idle();

        // Reset during the third MDU cycle
        issue(OP_REG, 3'b000, 7'h01, 0);
        cyc();
        cyc();
        check("mdu_cycle3", obs(), 7'b101_0001);
        rst = 1;
        cyc();
        check("rst_in_mdu", obs(), 7'b000_0000);
        idle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(63) == 0);
            stall = ($urandom_range(3) == 0);
            wake = ($urandom_range(2) == 0);
            branch_taken = ($urandom_range(5) == 0);
            case ($urandom_range(4))
                0: opcode = OP_LOAD;
                1: opcode = OP_ECALL;
                2, 3: opcode = OP_REG;
                default: opcode = 7'($urandom);
            endcase
            funct3 = 3'($urandom);
            funct7 = ($urandom_range(1) == 0) ? 7'h01 : 7'($urandom);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
